// File: rtl/quick_cpu_core.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : quick_cpu_core                                             |
// | Description : Multi-cycle fetch/execute core with four general           |
// |               registers, Z/C flags, immediates, jumps and halt.          |
// |               Program and data share one ready/valid memory bus.         |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
// | Ports                                                                    |
// |   clk          in   rising-edge clock                                    |
// |   rst_n        in   asynchronous active-low reset                        |
// |   i_run        in   low = pause at the next instruction boundary         |
// |   o_mem_req    out  memory request valid (registered)                    |
// |   o_mem_we     out  1 = write, 0 = read                                  |
// |   o_mem_addr   out  request address                                      |
// |   o_mem_wdata  out  store data                                           |
// |   i_mem_ready  in   memory accepts/completes the request this cycle      |
// |   i_mem_rdata  in   read data, valid with i_mem_ready on a read          |
// |   o_halted     out  HLT has executed                                     |
// |   i_dbg_sel    in   debug register select                                |
// |   o_dbg_reg    out  combinational value of register i_dbg_sel            |
// |   o_dbg_pc     out  current program counter                              |
// +--------------------------------------------------------------------------+
module quick_cpu_core #(
  parameter int DATA_W = 8,   // register/data width, at least 8
  parameter int ADDR_W = 8    // address and PC width
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_run,
  output logic              o_mem_req,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic              i_mem_ready,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic              o_halted,
  input  logic [1:0]        i_dbg_sel,
  output logic [DATA_W-1:0] o_dbg_reg,
  output logic [ADDR_W-1:0] o_dbg_pc
);

  localparam logic [3:0] c_OP_LD  = 4'h1;
  localparam logic [3:0] c_OP_ST  = 4'h2;
  localparam logic [3:0] c_OP_MOV = 4'h3;
  localparam logic [3:0] c_OP_ADD = 4'h4;
  localparam logic [3:0] c_OP_SUB = 4'h5;
  localparam logic [3:0] c_OP_AND = 4'h6;
  localparam logic [3:0] c_OP_OR  = 4'h7;
  localparam logic [3:0] c_OP_XOR = 4'h8;
  localparam logic [3:0] c_OP_LDI = 4'h9;
  localparam logic [3:0] c_OP_JMP = 4'hA;
  localparam logic [3:0] c_OP_JZ  = 4'hB;
  localparam logic [3:0] c_OP_INC = 4'hC;
  localparam logic [3:0] c_OP_HLT = 4'hF;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_EXEC  = 3'd2,
    S_MEM   = 3'd3,
    S_HALT  = 3'd4
  } state_t;

  state_t              r_state;
  logic [DATA_W-1:0]   r_regs [4];
  logic [ADDR_W-1:0]   r_pc;
  logic [7:0]          r_instr;
  logic                r_z;
  logic                r_c;
  logic                r_mem_req;
  logic                r_mem_we;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [DATA_W-1:0]   r_mem_wdata;
  logic                r_halted;

  logic [3:0]          w_op;
  logic [1:0]          w_rd;
  logic [1:0]          w_rs;
  logic [DATA_W-1:0]   w_rd_val;
  logic [DATA_W-1:0]   w_rs_val;
  logic [ADDR_W-1:0]   w_rs_addr;
  logic [ADDR_W-1:0]   w_pc_inc;
  logic [DATA_W:0]     w_alu;     // MSB carries carry-out / borrow

  assign w_op     = r_instr[7:4];
  assign w_rd     = r_instr[3:2];
  assign w_rs     = r_instr[1:0];
  assign w_rd_val = r_regs[w_rd];
  assign w_rs_val = r_regs[w_rs];
  assign w_pc_inc = r_pc + ADDR_W'(1);

  // A register used as an address is cut down or zero-extended to ADDR_W.
  generate
    if (DATA_W >= ADDR_W) begin : g_addr_trunc
      assign w_rs_addr = w_rs_val[ADDR_W-1:0];
    end else begin : g_addr_zext
      assign w_rs_addr = {{(ADDR_W-DATA_W){1'b0}}, w_rs_val};
    end
  endgenerate

  // Zero-extending both operands by one bit makes the MSB of a subtract
  // the borrow (set exactly when rd < rs).
  always_comb begin
    w_alu = '0;
    case (w_op)
      c_OP_ADD: w_alu = {1'b0, w_rd_val} + {1'b0, w_rs_val};
      c_OP_SUB: w_alu = {1'b0, w_rd_val} - {1'b0, w_rs_val};
      c_OP_AND: w_alu = {1'b0, w_rd_val & w_rs_val};
      c_OP_OR:  w_alu = {1'b0, w_rd_val | w_rs_val};
      c_OP_XOR: w_alu = {1'b0, w_rd_val ^ w_rs_val};
      c_OP_INC: w_alu = {1'b0, w_rd_val} + {{DATA_W{1'b0}}, 1'b1};
      default:  w_alu = '0;
    endcase
  end

  // Bus outputs are registered and only change on the accepting edge, so the
  // request stays stable across wait states.  Leaving IDLE raises the fetch
  // request on the same edge; after a retirement FETCH spends one cycle
  // raising it, so a plain instruction costs request, accept and execute.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_pc        <= '0;
      r_instr     <= '0;
      r_z         <= 1'b0;
      r_c         <= 1'b0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_halted    <= 1'b0;
      for (int i = 0; i < 4; i++) r_regs[i] <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_run) begin
            r_state    <= S_FETCH;
            r_mem_req  <= 1'b1;
            r_mem_we   <= 1'b0;
            r_mem_addr <= r_pc;
          end
        end
        S_FETCH: begin
          if (!r_mem_req) begin
            r_mem_req  <= 1'b1;
            r_mem_we   <= 1'b0;
            r_mem_addr <= r_pc;
          end else if (i_mem_ready) begin
            r_instr   <= i_mem_rdata[7:0];
            r_pc      <= w_pc_inc;
            r_mem_req <= 1'b0;
            r_state   <= S_EXEC;
          end
        end
        S_EXEC: begin
          r_state <= i_run ? S_FETCH : S_IDLE;
          case (w_op)
            c_OP_ADD, c_OP_SUB, c_OP_AND, c_OP_OR, c_OP_XOR, c_OP_INC: begin
              r_regs[w_rd] <= w_alu[DATA_W-1:0];
              r_c          <= w_alu[DATA_W];
              r_z          <= (w_alu[DATA_W-1:0] == '0);
            end
            c_OP_MOV: r_regs[w_rd] <= w_rs_val;
            c_OP_JMP: r_pc <= w_rs_addr;
            c_OP_JZ: begin
              if (r_z) r_pc <= w_rs_addr;
            end
            c_OP_LD: begin
              r_mem_req  <= 1'b1;
              r_mem_we   <= 1'b0;
              r_mem_addr <= w_rs_addr;
              r_state    <= S_MEM;
            end
            c_OP_ST: begin
              r_mem_req   <= 1'b1;
              r_mem_we    <= 1'b1;
              r_mem_addr  <= w_rs_addr;
              r_mem_wdata <= w_rd_val;
              r_state     <= S_MEM;
            end
            c_OP_LDI: begin
              r_mem_req  <= 1'b1;
              r_mem_we   <= 1'b0;
              r_mem_addr <= r_pc;
              r_state    <= S_MEM;
            end
            c_OP_HLT: begin
              r_halted <= 1'b1;
              r_state  <= S_HALT;
            end
            default: ;  // NOP and the unused opcodes D, E
          endcase
        end
        S_MEM: begin
          if (i_mem_ready) begin
            r_mem_req <= 1'b0;
            r_mem_we  <= 1'b0;
            if (w_op != c_OP_ST) r_regs[w_rd] <= i_mem_rdata;
            if (w_op == c_OP_LDI) r_pc <= w_pc_inc;
            r_state <= i_run ? S_FETCH : S_IDLE;
          end
        end
        S_HALT: begin
          r_mem_req <= 1'b0;
          r_halted  <= 1'b1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_mem_req   = r_mem_req;
  assign o_mem_we    = r_mem_we;
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_wdata = r_mem_wdata;
  assign o_halted    = r_halted;
  assign o_dbg_reg   = r_regs[i_dbg_sel];
  assign o_dbg_pc    = r_pc;

endmodule
`default_nettype wire

// File: tb/tb_quick_cpu_core.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_quick_cpu_core                                          |
// | Description : Directed bench for quick_cpu_core: an 8/8 instance and a   |
// |               16/12 instance, each with a simple memory model.           |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_quick_cpu_core;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // ---------------- instance A: DATA_W=8, ADDR_W=8 ----------------
  logic       rstA_n, runA, readyA, reqA, weA, haltedA;
  logic [7:0] addrA, wdataA, rdataA, dbgA, pcA;
  logic [1:0] selA;
  logic [7:0] memA [256];
  logic       ldA_en;
  logic [7:0] ldA_addr, ldA_data;
  int         fcnt = 0;
  logic [7:0] flog [1024];

  assign rdataA = memA[addrA];

  always @(posedge clk) begin
    if (ldA_en) memA[ldA_addr] <= ldA_data;
    else if (reqA && weA && readyA) memA[addrA] <= wdataA;
  end

  // Log of every accepted read address on bus A.
  always @(posedge clk) begin
    if (reqA && !weA && readyA) begin
      flog[fcnt % 1024] <= addrA;
      fcnt <= fcnt + 1;
    end
  end

  quick_cpu_core #(.DATA_W(8), .ADDR_W(8)) dutA (
    .clk(clk), .rst_n(rstA_n), .i_run(runA),
    .o_mem_req(reqA), .o_mem_we(weA), .o_mem_addr(addrA), .o_mem_wdata(wdataA),
    .i_mem_ready(readyA), .i_mem_rdata(rdataA), .o_halted(haltedA),
    .i_dbg_sel(selA), .o_dbg_reg(dbgA), .o_dbg_pc(pcA)
  );

  // ---------------- instance B: DATA_W=16, ADDR_W=12 ----------------
  logic        rstB_n, runB, readyB, reqB, weB, haltedB;
  logic [11:0] addrB, pcB;
  logic [15:0] wdataB, rdataB, dbgB;
  logic [1:0]  selB;
  logic [15:0] memB [4096];
  logic        ldB_en;
  logic [11:0] ldB_addr;
  logic [15:0] ldB_data;

  assign rdataB = memB[addrB];

  always @(posedge clk) begin
    if (ldB_en) memB[ldB_addr] <= ldB_data;
    else if (reqB && weB && readyB) memB[addrB] <= wdataB;
  end

  quick_cpu_core #(.DATA_W(16), .ADDR_W(12)) dutB (
    .clk(clk), .rst_n(rstB_n), .i_run(runB),
    .o_mem_req(reqB), .o_mem_we(weB), .o_mem_addr(addrB), .o_mem_wdata(wdataB),
    .i_mem_ready(readyB), .i_mem_rdata(rdataB), .o_halted(haltedB),
    .i_dbg_sel(selB), .o_dbg_reg(dbgB), .o_dbg_pc(pcB)
  );

  // ---------------- helpers ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic ldA(input int a, input logic [7:0] d);
    ldA_en = 1'b1; ldA_addr = a[7:0]; ldA_data = d;
    @(negedge clk);
    ldA_en = 1'b0;
  endtask

  task automatic ldB(input int a, input logic [15:0] d);
    ldB_en = 1'b1; ldB_addr = a[11:0]; ldB_data = d;
    @(negedge clk);
    ldB_en = 1'b0;
  endtask

  task automatic clearA();
    for (int i = 0; i < 256; i++) ldA(i, 8'h00);
  endtask

  task automatic rdA(input logic [1:0] s, output logic [7:0] v);
    selA = s; #1; v = dbgA;
  endtask

  task automatic rdB(input logic [1:0] s, output logic [15:0] v);
    selB = s; #1; v = dbgB;
  endtask

  task automatic holdA();
    @(negedge clk);
    rstA_n = 1'b0; readyA = 1'b1; runA = 1'b1;
    @(negedge clk);
  endtask

  task automatic releaseA();
    @(negedge clk);
    rstA_n = 1'b1;
  endtask

  task automatic wait_haltA(input string tag, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (haltedA) break;
      @(negedge clk);
    end
    chk(tag, haltedA, 1'b1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0]  v8;
    logic [15:0] v16;
    int          base;

    rstA_n = 1'b0; runA = 1'b1; readyA = 1'b1; selA = 2'd0; ldA_en = 1'b0;
    ldA_addr = '0; ldA_data = '0;
    rstB_n = 1'b0; runB = 1'b1; readyB = 1'b1; selB = 2'd0; ldB_en = 1'b0;
    ldB_addr = '0; ldB_data = '0;

    // ---- reset state ----
    @(negedge clk);
    clearA();
    chk("rst_req", reqA, 1'b0);
    chk("rst_we", weA, 1'b0);
    chk("rst_addr", addrA, 8'h00);
    chk("rst_wdata", wdataA, 8'h00);
    chk("rst_halted", haltedA, 1'b0);
    chk("rst_pc", pcA, 8'h00);
    for (int r = 0; r < 4; r++) begin
      rdA(r[1:0], v8);
      chk("rst_reg", v8, 8'h00);
    end

    // ---- scenario 1: LDI r3,5 ; ADD r3,r3 ; JZ r3 (not taken) ; NOP ; NOP ; HLT @5 ----
    ldA(0, 8'h9C); ldA(1, 8'h05); ldA(2, 8'h4F); ldA(3, 8'hB3);
    ldA(4, 8'h00); ldA(5, 8'hF0);
    releaseA();
    @(negedge clk);
    chk("s1_first_req", reqA, 1'b1);
    chk("s1_first_addr", addrA, 8'h00);
    repeat (5) @(negedge clk);
    rdA(2'd3, v8);
    chk("s1_r3_after_ldi", v8, 8'h05);
    @(negedge clk);
    rdA(2'd3, v8);
    chk("s1_r3_after_add", v8, 8'h0A);
    wait_haltA("s1_halt", 60);
    chk("s1_pc", pcA, 8'h06);
    chk("s1_z", dutA.r_z, 1'b0);
    chk("s1_c", dutA.r_c, 1'b0);
    repeat (5) @(negedge clk);
    chk("s1_req_after_halt", reqA, 1'b0);
    chk("s1_still_halted", haltedA, 1'b1);

    // ---- scenario 2: r0=FF, r1=01, r2=10, ADD r0,r1, JZ r2 -> HLT @10 ----
    holdA();
    ldA(0, 8'h90); ldA(1, 8'hFF); ldA(2, 8'h94); ldA(3, 8'h01);
    ldA(4, 8'h98); ldA(5, 8'h10); ldA(6, 8'h41); ldA(7, 8'hB2);
    ldA(16, 8'hF0);
    base = fcnt;
    releaseA();
    wait_haltA("s2_halt", 80);
    rdA(2'd0, v8); chk("s2_r0", v8, 8'h00);
    rdA(2'd1, v8); chk("s2_r1", v8, 8'h01);
    rdA(2'd2, v8); chk("s2_r2", v8, 8'h10);
    chk("s2_z", dutA.r_z, 1'b1);
    chk("s2_c", dutA.r_c, 1'b1);
    chk("s2_fetch_jz", flog[(base + 7) % 1024], 8'h07);
    chk("s2_fetch_target", flog[(base + 8) % 1024], 8'h10);
    chk("s2_pc", pcA, 8'h11);

    // ---- scenario 3: MOV/AND/OR/XOR/INC/SUB mix ----
    holdA();
    ldA(0, 8'h90); ldA(1, 8'h3C); ldA(2, 8'h94); ldA(3, 8'h0F);
    ldA(4, 8'h38); ldA(5, 8'h69); ldA(6, 8'h7D); ldA(7, 8'h8C);
    ldA(8, 8'hC0); ldA(9, 8'h54); ldA(10, 8'hF0);
    releaseA();
    wait_haltA("s3_halt", 80);
    rdA(2'd0, v8); chk("s3_r0_inc", v8, 8'h3D);
    rdA(2'd1, v8); chk("s3_r1_sub", v8, 8'hD2);
    rdA(2'd2, v8); chk("s3_r2_mov_and", v8, 8'h0C);
    rdA(2'd3, v8); chk("s3_r3_or_xor", v8, 8'h33);
    chk("s3_c_borrow", dutA.r_c, 1'b1);
    chk("s3_z", dutA.r_z, 1'b0);

    // ---- scenario 4: ST r1,[r2] with 3 wait states ; LD r3,[r2] ; JMP r0 ----
    holdA();
    ldA(0, 8'h94); ldA(1, 8'hA5); ldA(2, 8'h98); ldA(3, 8'h80);
    ldA(4, 8'h26); ldA(5, 8'h1E); ldA(6, 8'h90); ldA(7, 8'h20);
    ldA(8, 8'hA0); ldA(32, 8'hF0); ldA(128, 8'h00);
    releaseA();
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (reqA && weA) break;
    end
    chk("s4_st_seen", {reqA, weA}, 2'b11);
    readyA = 1'b0;
    chk("s4_addr_c0", addrA, 8'h80);
    chk("s4_wdata_c0", wdataA, 8'hA5);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      chk("s4_req_stall", reqA, 1'b1);
      chk("s4_we_stall", weA, 1'b1);
      chk("s4_addr_stall", addrA, 8'h80);
      chk("s4_wdata_stall", wdataA, 8'hA5);
      chk("s4_mem_untouched", memA[128], 8'h00);
    end
    readyA = 1'b1;
    @(negedge clk);
    chk("s4_req_dropped", reqA, 1'b0);
    chk("s4_mem_written", memA[128], 8'hA5);
    wait_haltA("s4_halt", 80);
    rdA(2'd3, v8); chk("s4_r3_ld", v8, 8'hA5);
    chk("s4_pc_jmp", pcA, 8'h21);

    // ---- scenario 5: PC wrap over all-NOP memory ----
    holdA();
    clearA();
    base = fcnt;
    releaseA();
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (fcnt - base >= 258) break;
    end
    chk("s5_fetch_count_reached", (fcnt - base >= 258), 1'b1);
    chk("s5_first_fetch", flog[base % 1024], 8'h00);
    chk("s5_fetch_ff", flog[(base + 255) % 1024], 8'hFF);
    chk("s5_fetch_wrap", flog[(base + 256) % 1024], 8'h00);
    chk("s5_fetch_after_wrap", flog[(base + 257) % 1024], 8'h01);

    // ---- scenario 6: async reset in MEM, then run gating ----
    holdA();
    ldA(0, 8'h94); ldA(1, 8'h77); ldA(2, 8'h90); ldA(3, 8'h55);
    releaseA();
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (reqA && !weA && addrA == 8'h03) break;
    end
    readyA = 1'b0;
    chk("s6_mem_req_seen", {reqA, addrA}, {1'b1, 8'h03});
    rdA(2'd1, v8); chk("s6_r1_before", v8, 8'h77);
    #1;
    rstA_n = 1'b0;
    #1;
    chk("s6_async_req", reqA, 1'b0);
    chk("s6_async_addr", addrA, 8'h00);
    chk("s6_async_pc", pcA, 8'h00);
    rdA(2'd1, v8); chk("s6_async_r1", v8, 8'h00);
    @(negedge clk);
    runA = 1'b0; readyA = 1'b1; rstA_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("s6_paused_req", reqA, 1'b0);
    runA = 1'b1;
    @(negedge clk);
    chk("s6_refetch_req", reqA, 1'b1);
    chk("s6_refetch_addr", addrA, 8'h00);

    // ---- scenario 7: scenario 1 on DATA_W=16, ADDR_W=12 ----
    ldB(0, 16'hAB9C); ldB(1, 16'h8005); ldB(2, 16'h004F); ldB(3, 16'h00B3);
    ldB(4, 16'h0000); ldB(5, 16'h00F0);
    @(negedge clk);
    rstB_n = 1'b1;
    @(negedge clk);
    chk("s7_first_req", reqB, 1'b1);
    chk("s7_first_addr", addrB, 12'h000);
    for (int i = 0; i < 80; i++) begin
      if (haltedB) break;
      @(negedge clk);
    end
    chk("s7_halt", haltedB, 1'b1);
    rdB(2'd3, v16); chk("s7_r3", v16, 16'h000A);
    chk("s7_c", dutB.r_c, 1'b1);
    chk("s7_z", dutB.r_z, 1'b0);
    chk("s7_pc", pcB, 12'h006);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
